// File: rtl/floo_route_lookup_arb.sv
// Round-robin arbiter that shares one combinational route-lookup unit among NumReq requesters.
// Each accepted request walks IDLE -> LOOKUP -> RESP and returns {idx, id, route, err}.
// Optional lookup/error counters are enabled by defining FLOO_ROUTE_LKP_STATS_EN.
module floo_route_lookup_arb #(
    parameter int unsigned NumReq     = 4,
    parameter int unsigned AddrWidth  = 48,
    parameter int unsigned IdWidth    = 8,
    parameter int unsigned RouteWidth = 16,
    localparam int unsigned IdxWidth  = $clog2(NumReq)
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [NumReq-1:0]           req_valid_i,
    input  logic [NumReq*AddrWidth-1:0] req_addr_i,
    output logic [NumReq-1:0]           req_ready_o,
    output logic [AddrWidth-1:0]        lkp_addr_o,
    input  logic [IdWidth-1:0]          lkp_id_i,
    input  logic [RouteWidth-1:0]       lkp_route_i,
    input  logic                        lkp_err_i,
    output logic                        rsp_valid_o,
    input  logic                        rsp_ready_i,
    output logic [IdxWidth-1:0]         rsp_idx_o,
    output logic [IdWidth-1:0]          rsp_id_o,
    output logic [RouteWidth-1:0]       rsp_route_o,
    output logic                        rsp_err_o,
    output logic [31:0]                 stat_lkp_o,
    output logic [31:0]                 stat_err_o
);

    typedef enum logic [1:0] {StIdle, StLookup, StResp} state_e;

    state_e                state_q, state_d;
    logic [IdxWidth-1:0]   rr_ptr_q, rr_ptr_d;
    logic [AddrWidth-1:0]  addr_q, addr_d;
    logic [IdxWidth-1:0]   idx_q, idx_d;
    logic [IdWidth-1:0]    id_q, id_d;
    logic [RouteWidth-1:0] route_q, route_d;
    logic                  err_q, err_d;

    logic                  gnt_valid;
    logic [IdxWidth-1:0]   gnt_idx;
    logic                  accept;
    logic                  rsp_hs;

    // Round-robin search: lowest valid index at or above rr_ptr, wrapping to 0.
    always_comb begin
        int unsigned cand;
        cand      = 0;
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        for (int unsigned k = 0; k < NumReq; k++) begin
            cand = (32'(rr_ptr_q) + k) % NumReq;
            if (!gnt_valid && req_valid_i[cand[IdxWidth-1:0]]) begin
                gnt_valid = 1'b1;
                gnt_idx   = cand[IdxWidth-1:0];
            end
        end
    end

    assign accept = (state_q == StIdle) && gnt_valid;
    assign rsp_hs = (state_q == StResp) && rsp_ready_i;

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= StIdle;
        else       state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (gnt_valid) state_d = StLookup;
            StLookup: state_d = StResp;
            StResp:   if (rsp_ready_i) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // FSM outputs; ready is masked during reset and never looks at rsp_ready_i.
    always_comb begin
        req_ready_o = '0;
        if (accept && !rst_i) req_ready_o[gnt_idx] = 1'b1;
        rsp_valid_o = (state_q == StResp);
        lkp_addr_o  = addr_q;
    end

    // Datapath next-state: latch grant on accept, lookup results at end of LOOKUP.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        addr_d   = addr_q;
        idx_d    = idx_q;
        id_d     = id_q;
        route_d  = route_q;
        err_d    = err_q;
        if (accept) begin
            addr_d   = req_addr_i[32'(gnt_idx)*AddrWidth +: AddrWidth];
            idx_d    = gnt_idx;
            rr_ptr_d = (32'(gnt_idx) == NumReq - 1) ? '0 : gnt_idx + 1'b1;
        end
        if (state_q == StLookup) begin
            id_d    = lkp_id_i;
            route_d = lkp_route_i;
            err_d   = lkp_err_i;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr_q <= '0;
            addr_q   <= '0;
            idx_q    <= '0;
            id_q     <= '0;
            route_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            addr_q   <= addr_d;
            idx_q    <= idx_d;
            id_q     <= id_d;
            route_q  <= route_d;
            err_q    <= err_d;
        end
    end

    assign rsp_idx_o   = idx_q;
    assign rsp_id_o    = id_q;
    assign rsp_route_o = route_q;
    assign rsp_err_o   = err_q;

`ifdef FLOO_ROUTE_LKP_STATS_EN
    logic [31:0] lkp_cnt_q, lkp_cnt_d;
    logic [31:0] err_cnt_q, err_cnt_d;

    // Counters bump once per completed handshake and wrap naturally.
    always_comb begin
        lkp_cnt_d = lkp_cnt_q;
        err_cnt_d = err_cnt_q;
        if (rsp_hs) begin
            lkp_cnt_d = lkp_cnt_q + 32'd1;
            if (err_q) err_cnt_d = err_cnt_q + 32'd1;
        end
    end

    // Counter registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lkp_cnt_q <= '0;
            err_cnt_q <= '0;
        end else begin
            lkp_cnt_q <= lkp_cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign stat_lkp_o = lkp_cnt_q;
    assign stat_err_o = err_cnt_q;
`else
    logic unused_rsp_hs;
    assign unused_rsp_hs = rsp_hs;
    assign stat_lkp_o    = '0;
    assign stat_err_o    = '0;
`endif

endmodule

// File: tb/tb_floo_route_lookup_arb.sv
// Self-checking bench for floo_route_lookup_arb with a queue-free behavioural reference model.
// Define FLOO_ROUTE_LKP_STATS_EN to also check the statistics counters.
module tb_floo_route_lookup_arb;

    localparam int NR = 4;
    localparam int AW = 48;

    logic            clk = 1'b0;
    logic            rst;
    logic [NR-1:0]   req_valid;
    logic [AW-1:0]   addr_arr [NR];
    logic [NR*AW-1:0] req_addr;
    logic [NR-1:0]   req_ready;
    logic [AW-1:0]   lkp_addr;
    logic [7:0]      lkp_id;
    logic [15:0]     lkp_route;
    logic            lkp_err;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [1:0]      rsp_idx;
    logic [7:0]      rsp_id;
    logic [15:0]     rsp_route;
    logic            rsp_err;
    logic [31:0]     stat_lkp;
    logic [31:0]     stat_err;

    // Lookup unit stand-in: result is a fixed function of the address and bench-chosen salts.
    logic [7:0]      id_salt;
    logic [15:0]     route_salt;
    logic            err_salt;

    int pass_cnt  = 0;
    int check_cnt = 0;
    int exp_lkp   = 0;
    int exp_err   = 0;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NR; i++) req_addr[i*AW +: AW] = addr_arr[i];
    end

    assign lkp_id    = lkp_addr[7:0] ^ id_salt;
    assign lkp_route = lkp_addr[15:0] ^ route_salt;
    assign lkp_err   = lkp_addr[0] ^ err_salt;

    floo_route_lookup_arb dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (req_valid),
        .req_addr_i  (req_addr),
        .req_ready_o (req_ready),
        .lkp_addr_o  (lkp_addr),
        .lkp_id_i    (lkp_id),
        .lkp_route_i (lkp_route),
        .lkp_err_i   (lkp_err),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_idx_o   (rsp_idx),
        .rsp_id_o    (rsp_id),
        .rsp_route_o (rsp_route),
        .rsp_err_o   (rsp_err),
        .stat_lkp_o  (stat_lkp),
        .stat_err_o  (stat_err)
    );

    function automatic logic [31:0] xs_lkp();
`ifdef FLOO_ROUTE_LKP_STATS_EN
        return 32'(exp_lkp);
`else
        return 32'd0;
`endif
    endfunction

    function automatic logic [31:0] xs_err();
`ifdef FLOO_ROUTE_LKP_STATS_EN
        return 32'(exp_err);
`else
        return 32'd0;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        req_valid  = '1;
        rsp_ready  = 1'b0;
        tick();
        #1;
        check_cnt++;
        if (req_ready !== 4'b0000) $display("FAIL ready_in_reset: got %b want 0000", req_ready);
        else pass_cnt++;
        tick();
        rst       = 1'b0;
        req_valid = '0;
        exp_lkp   = 0;
        exp_err   = 0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        check_cnt++;
        if ({rsp_valid, req_ready, lkp_addr} !== '0)
            $display("FAIL reset_ctrl: got v=%b rdy=%b a=%0h want 0", rsp_valid, req_ready, lkp_addr);
        else pass_cnt++;
        check_cnt++;
        if ({rsp_idx, rsp_id, rsp_route, rsp_err} !== '0)
            $display("FAIL reset_payload: got %0h want 0", {rsp_idx, rsp_id, rsp_route, rsp_err});
        else pass_cnt++;
        check_cnt++;
        if ({stat_lkp, stat_err} !== 64'd0)
            $display("FAIL reset_stats: got %0h/%0h want 0/0", stat_lkp, stat_err);
        else pass_cnt++;
    endtask

    task automatic test_single();
        do_reset();
        addr_arr[2] = 48'h1000;
        id_salt     = 8'h05;
        route_salt  = 16'h10A3;
        err_salt    = 1'b0;
        rsp_ready   = 1'b1;
        req_valid   = 4'b0100;
        #1;
        check_cnt++;
        if (req_ready !== 4'b0100) $display("FAIL single_grant: got %b want 0100", req_ready);
        else pass_cnt++;
        tick();
        req_valid = '0;
        #1;
        check_cnt++;
        if (rsp_valid !== 1'b0 || lkp_addr !== 48'h1000)
            $display("FAIL single_lookup: got v=%b a=%0h want v=0 a=1000", rsp_valid, lkp_addr);
        else pass_cnt++;
        tick();
        #1;
        check_cnt++;
        if ({rsp_valid, rsp_idx, rsp_id, rsp_route, rsp_err} !== {1'b1, 2'd2, 8'h05, 16'h00A3, 1'b0})
            $display("FAIL single_rsp: got v=%b idx=%0d id=%0h rt=%0h e=%b want 1 2 05 00a3 0",
                     rsp_valid, rsp_idx, rsp_id, rsp_route, rsp_err);
        else pass_cnt++;
        tick();
        exp_lkp++;
        #1;
        check_cnt++;
        if (rsp_valid !== 1'b0 || stat_lkp !== xs_lkp())
            $display("FAIL single_done: got v=%b cnt=%0d want v=0 cnt=%0d", rsp_valid, stat_lkp, xs_lkp());
        else pass_cnt++;
    endtask

    task automatic test_round_robin();
        logic [NR-1:0] exp;
        do_reset();
        for (int i = 0; i < NR; i++) addr_arr[i] = 48'(i * 16 + 'h100);
        rsp_ready = 1'b1;
        req_valid = '1;
        for (int c = 0; c < 15; c++) begin
            #1;
            exp = (c % 3 == 0) ? NR'(1 << ((c / 3) % NR)) : '0;
            check_cnt++;
            if (req_ready !== exp) $display("FAIL rr_grant c%0d: got %b want %b", c, req_ready, exp);
            else pass_cnt++;
            if (c % 3 == 2) exp_lkp++;
            tick();
        end
        req_valid = '0;
        #1;
        check_cnt++;
        if (stat_lkp !== xs_lkp()) $display("FAIL rr_stats: got %0d want %0d", stat_lkp, xs_lkp());
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        logic [26:0] exp_pl;
        do_reset();
        addr_arr[0] = 48'hABCD_0032;
        id_salt     = 8'h11;
        route_salt  = 16'h2222;
        err_salt    = 1'b0;
        rsp_ready   = 1'b0;
        req_valid   = 4'b0001;
        exp_pl      = {2'd0, 8'h32 ^ 8'h11, 16'h0032 ^ 16'h2222, 1'b0};
        tick();
        req_valid = 4'b1110;
        tick();
        for (int c = 0; c < 6; c++) begin
            if (c == 5) rsp_ready = 1'b1;
            #1;
            check_cnt++;
            if (rsp_valid !== 1'b1 || req_ready !== '0 || {rsp_idx, rsp_id, rsp_route, rsp_err} !== exp_pl)
                $display("FAIL bp_hold c%0d: got v=%b rdy=%b pl=%0h want v=1 rdy=0 pl=%0h",
                         c, rsp_valid, req_ready, {rsp_idx, rsp_id, rsp_route, rsp_err}, exp_pl);
            else pass_cnt++;
            tick();
        end
        exp_lkp++;
        req_valid = '0;
        #1;
        check_cnt++;
        if (rsp_valid !== 1'b0 || stat_lkp !== xs_lkp())
            $display("FAIL bp_done: got v=%b cnt=%0d want v=0 cnt=%0d", rsp_valid, stat_lkp, xs_lkp());
        else pass_cnt++;
    endtask

    task automatic test_error();
        do_reset();
        addr_arr[3] = 48'h55;
        id_salt     = 8'h00;
        route_salt  = 16'h0000;
        err_salt    = 1'b0;
        rsp_ready   = 1'b1;
        req_valid   = 4'b1000;
        tick();
        req_valid = '0;
        tick();
        #1;
        check_cnt++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_idx !== 2'd3)
            $display("FAIL err_rsp: got v=%b e=%b idx=%0d want 1 1 3", rsp_valid, rsp_err, rsp_idx);
        else pass_cnt++;
        check_cnt++;
        if (stat_lkp !== 32'd0 || stat_err !== 32'd0)
            $display("FAIL err_stats_before: got %0d/%0d want 0/0", stat_lkp, stat_err);
        else pass_cnt++;
        tick();
        exp_lkp++;
        exp_err++;
        check_cnt++;
        if (stat_lkp !== xs_lkp() || stat_err !== xs_err())
            $display("FAIL err_stats_after: got %0d/%0d want %0d/%0d", stat_lkp, stat_err, xs_lkp(), xs_err());
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        addr_arr[2] = 48'h777;
        rsp_ready   = 1'b1;
        req_valid   = 4'b0100;
        tick();
        req_valid = '0;
        rst       = 1'b1;
        tick();
        rst       = 1'b0;
        req_valid = '1;
        #1;
        check_cnt++;
        if (rsp_valid !== 1'b0 || lkp_addr !== '0)
            $display("FAIL midrst_idle: got v=%b a=%0h want v=0 a=0", rsp_valid, lkp_addr);
        else pass_cnt++;
        check_cnt++;
        if (req_ready !== 4'b0001) $display("FAIL midrst_grant: got %b want 0001", req_ready);
        else pass_cnt++;
        req_valid = '0;
        tick();
        tick();
        #1;
        check_cnt++;
        if (rsp_valid !== 1'b0) $display("FAIL midrst_norsp: got v=%b want 0", rsp_valid);
        else pass_cnt++;
    endtask

    // Randomized traffic against a transaction-level model of the arbiter.
    task automatic test_random();
        int            phase;   // 0 waiting, 1 lookup pending, 2 response pending
        int            ptr;
        int            g;
        logic [AW-1:0] m_addr;
        int            m_idx;
        logic [7:0]    m_id;
        logic [15:0]   m_route;
        logic          m_err;
        logic [NR-1:0] exp_rdy;
        do_reset();
        phase  = 0;
        ptr    = 0;
        m_addr = '0;
        m_idx  = 0;
        m_id   = '0;
        m_route = '0;
        m_err  = 1'b0;
        for (int c = 0; c < 400; c++) begin
            req_valid  = NR'($urandom & $urandom);
            for (int i = 0; i < NR; i++) addr_arr[i] = {16'($urandom), $urandom};
            rsp_ready  = ($urandom_range(0, 3) != 0);
            id_salt    = 8'($urandom);
            route_salt = 16'($urandom);
            err_salt   = 1'($urandom);
            #1;
            exp_rdy = '0;
            g       = -1;
            if (phase == 0) begin
                for (int k = 0; k < NR; k++)
                    if (g < 0 && req_valid[(ptr + k) % NR]) g = (ptr + k) % NR;
                if (g >= 0) exp_rdy = NR'(1 << g);
            end
            check_cnt++;
            if (req_ready !== exp_rdy || rsp_valid !== (phase == 2) || lkp_addr !== m_addr)
                $display("FAIL rand_ctrl c%0d: got rdy=%b v=%b a=%0h want rdy=%b v=%b a=%0h", c,
                         req_ready, rsp_valid, lkp_addr, exp_rdy, phase == 2, m_addr);
            else pass_cnt++;
            if (phase == 2) begin
                check_cnt++;
                if ({rsp_idx, rsp_id, rsp_route, rsp_err} !== {2'(m_idx), m_id, m_route, m_err})
                    $display("FAIL rand_payload c%0d: got %0h want %0h", c,
                             {rsp_idx, rsp_id, rsp_route, rsp_err}, {2'(m_idx), m_id, m_route, m_err});
                else pass_cnt++;
            end
            check_cnt++;
            if (stat_lkp !== xs_lkp() || stat_err !== xs_err())
                $display("FAIL rand_stats c%0d: got %0d/%0d want %0d/%0d", c, stat_lkp, stat_err,
                         xs_lkp(), xs_err());
            else pass_cnt++;
            case (phase)
                0: if (g >= 0) begin
                    m_addr = addr_arr[g];
                    m_idx  = g;
                    ptr    = (g + 1) % NR;
                    phase  = 1;
                end
                1: begin
                    m_id    = m_addr[7:0] ^ id_salt;
                    m_route = m_addr[15:0] ^ route_salt;
                    m_err   = m_addr[0] ^ err_salt;
                    phase   = 2;
                end
                default: if (rsp_ready) begin
                    exp_lkp++;
                    if (m_err) exp_err++;
                    phase = 0;
                end
            endcase
            tick();
        end
        req_valid = '0;
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = '0;
        rsp_ready  = 1'b0;
        id_salt    = '0;
        route_salt = '0;
        err_salt   = 1'b0;
        for (int i = 0; i < NR; i++) addr_arr[i] = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_error();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule

// File: doc/floo_route_lookup_arb.md
FLOO_ROUTE_LOOKUP_ARB -- requirements
Module: floo_route_lookup_arb

Interface
REQ-001 SHALL have parameter NumReq, default 4: number of requesters sharing one route-lookup unit, 2..16.
REQ-002 SHALL have parameter AddrWidth, default 48: request address width.
REQ-003 SHALL have parameter IdWidth, default 8: destination ID width.
REQ-004 SHALL have parameter RouteWidth, default 16: route vector width.
REQ-005 SHALL have ports clk_i input 1 (single clock); reset is synchronous and active-high: rst_i input 1.
REQ-006 SHALL have req_valid_i input NumReq: per-requester lookup request.
REQ-007 SHALL have req_addr_i input NumReq*AddrWidth: per-requester address, slice i = requester i.
REQ-008 SHALL have req_ready_o output NumReq: per-requester accept, one-hot or zero.
REQ-009 SHALL have lkp_addr_o output AddrWidth: address driven to the shared combinational route-lookup unit.
REQ-010 SHALL have lkp_id_i input IdWidth, lkp_route_i input RouteWidth, lkp_err_i input 1: lookup unit results for lkp_addr_o.
REQ-011 SHALL have rsp_valid_o output 1, rsp_ready_i input 1: shared response handshake.
REQ-012 SHALL have rsp_idx_o output $clog2(NumReq), rsp_id_o output IdWidth, rsp_route_o output RouteWidth, rsp_err_o output 1: response payload.
REQ-013 SHALL have stat_lkp_o output 32, stat_err_o output 32: lookup and error counters.

Function
REQ-014 SHALL implement FSM states IDLE, LOOKUP, RESP.
REQ-015 IDLE: if any req_valid_i set, SHALL assert req_ready_o for exactly one granted requester that cycle, register its address and index, go to LOOKUP; else stay IDLE, req_ready_o=0.
REQ-016 Arbitration SHALL be round-robin: grant lowest index >= rr_ptr with valid set, wrapping to 0; on grant rr_ptr <= (grant+1) mod NumReq.
REQ-017 req_ready_o SHALL be 0 in LOOKUP and RESP; req_ready_o SHALL NOT depend combinationally on rsp_ready_i.
REQ-018 LOOKUP: lkp_addr_o SHALL equal the registered address; lkp_id_i, lkp_route_i, lkp_err_i SHALL be captured at end of cycle; next state RESP.
REQ-019 lkp_addr_o SHALL hold its last registered value outside LOOKUP (no X, no glitch to other requester).
REQ-020 RESP: rsp_valid_o=1 with stable payload until rsp_valid_o && rsp_ready_i; then IDLE.
REQ-021 Latency: acceptance in cycle N SHALL yield rsp_valid_o in cycle N+2; minimum request-to-request spacing 3 cycles with rsp_ready_i held high.
REQ-022 Requester deasserting req_valid_i without grant SHALL be permitted; no grant issued to it.
REQ-023 rsp_err_o SHALL be passed through from lkp_err_i unmodified; error responses follow the same handshake.
REQ-024 Counters SHALL increment by 1 per completed response handshake (stat_lkp_o) and per handshake with rsp_err_o=1 (stat_err_o); wrap from 2^32-1 to 0.

Reset
REQ-025 On rst_i=1 at a clock edge: state IDLE, rr_ptr 0, rsp_valid_o 0, req_ready_o 0, lkp_addr_o 0, rsp_idx_o/rsp_id_o/rsp_route_o/rsp_err_o 0, counters 0.
REQ-026 Reset mid-LOOKUP or mid-RESP SHALL discard the in-flight lookup; no response issued for it.
REQ-027 req_ready_o SHALL be 0 in any cycle where rst_i=1.

Configuration
REQ-028 Macro FLOO_ROUTE_LKP_STATS_EN defined: counters per REQ-024 present.
REQ-029 Macro undefined: no counter flops; stat_lkp_o and stat_err_o SHALL be tied to 0; all other behaviour identical.

Verification
REQ-030 Single request: req_valid_i=4'b0100, addr=0x1000, lookup returns id=0x05, route=0x00A3 -> ready[2] cycle N, rsp_valid cycle N+2, idx=2, id=0x05, route=0x00A3, err=0.
REQ-031 All four requesting continuously after reset, rsp_ready_i=1 -> grant order 0,1,2,3,0; grants every 3 cycles.
REQ-032 Backpressure: rsp_ready_i=0 for 5 cycles in RESP -> payload stable 5 cycles, req_ready_o=0 throughout, completes on 6th cycle.
REQ-033 Lookup error: lkp_err_i=1 -> rsp_err_o=1; with FLOO_ROUTE_LKP_STATS_EN, stat_err_o 0->1 and stat_lkp_o 0->1 after handshake.
REQ-034 rst_i=1 during LOOKUP -> next cycle IDLE, rsp_valid_o=0, no response for that request, next grant starts at requester 0.
REQ-035 Counter wrap (stats enabled, counter forced to 0xFFFFFFFF) -> 0 after next handshake; macro undefined -> stat outputs 0 always.
